// File: rtl/mac3_window_stream.sv
// Streaming a*b+c over a three-sample window with run qualification and output backpressure.
// Optional saturation of the result to OUT_W bits is enabled by defining MAC_SAT_EN.
module mac3_window_stream #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 32,
  parameter int RUN   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validi,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_o,
  output logic             valido,
  output logic [OUT_W-1:0] data_out,
  input  logic             ready_i,
  output logic             ovf
);

  localparam int SW = 2*WIDTH + 1;
  localparam int CW = $clog2(RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(RUN);
  localparam logic [CW-1:0] RUN_PRE = CW'(RUN - 1);

  logic [WIDTH-1:0] h1;
  logic [WIDTH-1:0] h2;
  logic [CW-1:0]    run_cnt;
  logic             stall;
  logic             accept;
  logic             bubble;
  logic             produce;
  logic [SW-1:0]    op_a;
  logic [SW-1:0]    op_b;
  logic [SW-1:0]    op_c;
  logic [OUT_W-1:0] result;
  logic             result_ovf;

  assign stall   = valido && !ready_i;
  assign ready_o = !stall;
  assign accept  = validi && ready_o;
  assign bubble  = !validi && ready_o;
  // run_cnt+1 >= RUN rewritten so the compare cannot wrap at the counter width
  assign produce = accept && (run_cnt >= RUN_PRE);

  assign op_a = SW'(h2);
  assign op_b = SW'(h1);
  assign op_c = SW'(data_in);

`ifdef MAC_SAT_EN
  logic [SW-1:0] sum_full;

  assign sum_full = op_a * op_b + op_c;

  always_comb begin
    result     = sum_full[OUT_W-1:0];
    result_ovf = 1'b0;
    if ((sum_full >> OUT_W) != '0) begin
      result     = {OUT_W{1'b1}};
      result_ovf = 1'b1;
    end
  end
`else
  assign result     = OUT_W'(op_a * op_b + op_c);
  assign result_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      h1      <= '0;
      h2      <= '0;
      run_cnt <= '0;
    end else if (accept) begin
      h2 <= h1;
      h1 <= data_in;
      if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + 1'b1;
      end
    end else if (bubble) begin
      run_cnt <= '0;
    end
  end

`ifdef MAC_SAT_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (produce) begin
      ovf_q <= result_ovf;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = result_ovf;
`endif

  // A producing accept refills the output even when the old result is consumed this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valido   <= 1'b0;
      data_out <= '0;
    end else if (produce) begin
      valido   <= 1'b1;
      data_out <= result;
    end else if (valido && ready_i) begin
      valido <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac3_window_stream.sv
// Directed bench for mac3_window_stream: RUN=3 main instance plus a RUN=5 instance.
module tb_mac3_window_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        validi;
  logic [31:0] data_in;
  logic        ready_o;
  logic        valido;
  logic [31:0] data_out;
  logic        ready_i;
  logic        ovf;

  logic        validi5;
  logic [31:0] data_in5;
  logic        ready_o5;
  logic        valido5;
  logic [31:0] data_out5;
  logic        ovf5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac3_window_stream #(.WIDTH(32), .OUT_W(32), .RUN(3)) dut (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in), .ready_o(ready_o),
    .valido(valido), .data_out(data_out), .ready_i(ready_i), .ovf(ovf)
  );

  mac3_window_stream #(.WIDTH(32), .OUT_W(32), .RUN(5)) dut5 (
    .clk(clk), .rst(rst), .validi(validi5), .data_in(data_in5), .ready_o(ready_o5),
    .valido(valido5), .data_out(data_out5), .ready_i(1'b1), .ovf(ovf5)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one sample into the main instance and advance one cycle
  task automatic feed(input logic v, input logic [31:0] d);
    validi  = v;
    data_in = d;
    tick();
  endtask

  initial begin
    logic [31:0] exp_ovf_data;
    logic        exp_ovf_flag;

    rst      = 1'b1;
    validi   = 1'b1;
    data_in  = 32'hFFFF;
    ready_i  = 1'b1;
    validi5  = 1'b0;
    data_in5 = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_valido", valido, 0);
      check_eq("rst_data", data_out, 0);
      check_eq("rst_ready", ready_o, 1);
    end
    rst = 1'b0;

    // two samples after release: no output yet; third completes 2*3+4
    feed(1, 2);
    check_eq("post_rst_s1", valido, 0);
    feed(1, 3);
    check_eq("post_rst_s2", valido, 0);
    feed(1, 4);
    check_eq("basic_valid", valido, 1);
    check_eq("basic_10", data_out, 10);
    check_eq("basic_ovf", ovf, 0);
    feed(1, 5);
    check_eq("basic_17", data_out, 17);
    check_eq("basic_valid2", valido, 1);
    feed(0, 0);
    check_eq("drop_valido", valido, 0);
    check_eq("drop_hold", data_out, 17);

    // RUN=5 instance: 1..5 gives 3*4+5
    for (int i = 1; i <= 5; i++) begin
      validi5  = 1'b1;
      data_in5 = i;
      tick();
      if (i < 5) check_eq("run5_early", valido5, 0);
    end
    validi5 = 1'b0;
    check_eq("run5_valid", valido5, 1);
    check_eq("run5_17", data_out5, 17);
    tick();
    check_eq("run5_drop", valido5, 0);

    // run break: 1,1,0,1,1 then 6
    feed(1, 1);
    check_eq("brk_a", valido, 0);
    feed(1, 2);
    check_eq("brk_b", valido, 0);
    feed(0, 0);
    check_eq("brk_c", valido, 0);
    feed(1, 3);
    check_eq("brk_d", valido, 0);
    feed(1, 4);
    check_eq("brk_e", valido, 0);
    feed(1, 6);
    check_eq("brk_valid", valido, 1);
    check_eq("brk_18", data_out, 18);
    feed(0, 0);

    // backpressure: 10 pending, 7 offered while ready_i=0
    feed(1, 2);
    feed(1, 3);
    feed(1, 4);
    check_eq("bp_10", data_out, 10);
    ready_i = 1'b0;
    validi  = 1'b1;
    data_in = 7;
    #1;
    check_eq("bp_ready_low", ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_hold_data", data_out, 10);
      check_eq("bp_hold_valid", valido, 1);
      check_eq("bp_ready", ready_o, 0);
    end
    ready_i = 1'b1;
    #1;
    check_eq("bp_ready_back", ready_o, 1);
    tick();
    check_eq("bp_19", data_out, 19);
    check_eq("bp_valid", valido, 1);
    feed(0, 0);
    check_eq("bp_drop", valido, 0);

    // overflow: 0x10000*0x10000+1 = 2^32+1
`ifdef MAC_SAT_EN
    exp_ovf_data = 32'hFFFF_FFFF;
    exp_ovf_flag = 1'b1;
`else
    exp_ovf_data = 32'h1;
    exp_ovf_flag = 1'b0;
`endif
    feed(1, 32'h10000);
    feed(1, 32'h10000);
    feed(1, 32'h1);
    check_eq("ovf_valid", valido, 1);
    check_eq("ovf_data", data_out, exp_ovf_data);
    check_eq("ovf_flag", ovf, exp_ovf_flag);
    feed(0, 0);

    // reset mid-run
    feed(1, 2);
    feed(1, 3);
    rst    = 1'b1;
    validi = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", valido, 0);
    check_eq("mid_rst_data", data_out, 0);
    feed(1, 4);
    check_eq("mid_s4", valido, 0);
    feed(1, 5);
    check_eq("mid_s5", valido, 0);
    feed(1, 6);
    check_eq("mid_valid", valido, 1);
    check_eq("mid_26", data_out, 26);
    feed(0, 0);
    check_eq("mid_drop", valido, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
